// File: rtl/dec_pkg.sv
// Shared decode types and helpers for the grant sequencer.
// Index/one-hot widths, FSM states and a one-hot helper.
package dec_pkg;

  localparam int IDX_W = 3;
  localparam int OUT_W = 2 ** IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    GAP_ST = 2'd2
  } state_e;

  function automatic logic [OUT_W-1:0] onehot_of(
    input logic [IDX_W-1:0] idx
  );
    logic [OUT_W-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/dec3_8_grant_hold_timer.sv
// Loadable down-counter with a last-cycle flag.
// Shared by the hold and idle-gap timing.
module hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/dec3_8_grant.sv
// Registered 3-to-8 decoder driving a timed one-hot grant
// with early release and an idle gap between grants.
module dec3_8_grant
  import dec_pkg::*;
#(
  parameter int IDX_W  = 3,
  parameter int HOLD_W = 4,
  parameter int GAP    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      Y,
  input  logic                  out_en,
  input  logic [HOLD_W-1:0]     hold_len,
  input  logic                  done,
  output logic                  in_ready,
  output logic [2**IDX_W-1:0]   grant,
  output logic                  grant_vld,
  output logic [IDX_W-1:0]      last_idx,
  output logic [7:0]            grant_cnt
);

  localparam int OUT_W = 2 ** IDX_W;

  state_e            state_q, state_d;
  logic [OUT_W-1:0]  grant_q, grant_d;
  logic              vld_q, vld_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              hold_load;
  logic [HOLD_W-1:0] hold_val;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_exp;
  logic              gap_load;
  logic [1:0]        gap_cnt;
  logic              gap_exp;

  hold_timer #(.W(HOLD_W)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hold_load),
    .load_val (hold_val),
    .cnt      (hold_cnt),
    .expire   (hold_exp)
  );

  hold_timer #(.W(2)) u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (2'(GAP)),
    .cnt      (gap_cnt),
    .expire   (gap_exp)
  );

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    vld_d     = vld_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    hold_load = 1'b0;
    gap_load  = 1'b0;
    hold_val  = (hold_len == '0) ? HOLD_W'(1) : hold_len;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (out_en) begin
          grant_d   = onehot_of(Y);
          vld_d     = 1'b1;
          last_d    = Y;
          cnt_d     = cnt_q + 8'd1;
          hold_load = 1'b1;
          state_d   = GRANT;
        end
      end
      (state_q == GRANT): begin
        // expiry and done together still give one release
        if (hold_exp | done) begin
          grant_d = '0;
          vld_d   = 1'b0;
          if (GAP > 0) begin
            gap_load = 1'b1;
            state_d  = GAP_ST;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      (state_q == GAP_ST): begin
        if (gap_exp) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      vld_q   <= 1'b0;
      last_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant     = grant_q;
  assign grant_vld = vld_q;
  assign last_idx  = last_q;
  assign grant_cnt = cnt_q;

endmodule

// File: doc/dec3_8_grant.md
Name: dec3_8_grant

Overview:
- Registered 3-to-8 decoder and grant sequencer; the receiving end of the 8-to-3 priority encoder's (Y, out_en) interface.
- Accepts an encoded index when it is valid and ready, then drives a one-hot grant line for a programmable number of cycles or until early release.
- Inserts a configurable idle gap between grants.
- Sits between the priority encoder and the eight requester/resource select lines.

Parameters:
- IDX_W, 3, index width; OUT_W = 2**IDX_W (8), derived, not overridable.
- HOLD_W, 4, width of hold_len and the internal hold counter.
- GAP, 1, idle cycles (0..3) between grant release and the next in_ready.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Y  in  IDX_W  encoded index from the priority encoder.
- out_en  in  1  Y valid (encoder found an active request).
- hold_len  in  HOLD_W  grant duration in cycles, sampled on accept; 0 is treated as 1.
- done  in  1  early release from the granted requester.
- in_ready  out  1  block can accept a new index.
- grant  out  OUT_W  registered one-hot grant.
- grant_vld  out  1  high whenever grant is non-zero.
- last_idx  out  IDX_W  index of the most recent accepted request (sticky).
- grant_cnt  out  8  count of accepted requests, wraps 255->0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; grant=0; grant_vld=0; last_idx=0; grant_cnt=0; hold counter=0; gap counter=0; in_ready=1 once reset deasserts.
  - Outputs clear immediately on reset assertion, including mid-grant.
- FSM states: IDLE, GRANT, GAP_ST.
- IDLE:
  - in_ready=1 (combinational from state).
  - Accept = out_en & in_ready at a rising edge.
  - On accept: grant <= 1<<Y; grant_vld <= 1; last_idx <= Y; grant_cnt <= grant_cnt+1; cnt <= (hold_len==0 ? 1 : hold_len); state <= GRANT.
  - Latency: grant is visible in the cycle after the accepting edge.
  - Y is ignored when out_en=0; no state change.
- GRANT:
  - in_ready=0; grant is held stable; cnt decrements each edge.
  - Release when (cnt==1) | done at an edge. On release: grant <= 0; grant_vld <= 0; state <= GAP_ST if GAP>0, else IDLE.
  - Expiry and done in the same cycle produce a single release, with no double action.
  - done is ignored in IDLE and GAP_ST.
  - Grant duration is exactly max(hold_len,1) cycles without done; with done asserted in grant cycle n, the duration is n cycles.
- GAP_ST:
  - in_ready=0; grant=0. Gap counter loaded with GAP on entry.
  - Returns to IDLE after exactly GAP cycles.
  - out_en during the gap is not accepted; the encoder holds Y.
- Back-to-back (GAP=0): release edge → IDLE; the next accept is possible one cycle later, so there is at least 1 idle cycle between grants.
- grant is always one-hot or zero; never two bits set.
- grant_vld == |grant at all times.
- Y is unsigned; every value 0..7 is legal; no out-of-range case exists.

Decomposition:
- Shared package dec_pkg: state enum (IDLE, GRANT, GAP_ST), IDX_W/OUT_W constants, and a onehot_of(idx) function reusable by other decoders.
- Sub-module: hold_timer (load, decrement, expire flag, width HOLD_W), used for both the hold and gap counts.
- Decode and FSM stay in the top module.

Test Plan:
1. Reset mid-grant: accept Y=3, hold_len=8; assert rst_n=0 at grant cycle 4 → grant=0, grant_vld=0, grant_cnt=0, last_idx=0 immediately; in_ready=1 after release.
2. Basic decode: Y=4, out_en=1, hold_len=3, GAP=1 → grant=8'b0001_0000 for exactly 3 cycles starting the cycle after accept; in_ready=0 for 4 cycles total; grant_cnt=1; last_idx=4.
3. Sweep: Y=0..7 sequentially, hold_len=1 → grant walks 8'h01,02,04,…,80; each bit one cycle; never two bits set; grant_cnt=8.
4. Early release: Y=6, hold_len=10, done=1 in grant cycle 2 → grant=8'h40 for 2 cycles, then 0; done in IDLE → no effect.
5. hold_len=0: Y=2 → grant=8'h04 for exactly 1 cycle. Same-cycle case: done coincident with expiry → a single release and a single GAP_ST entry.
6. Back-pressure/wrap: out_en held high with Y=7 during GRANT and GAP_ST → no extra accepts until IDLE. 256 accepts → grant_cnt wraps to 0.
